// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO stream reader: buffer-occupancy state and its limit.
package fifo_stream_reader_pkg;

  // State encodes how many words the output buffer holds
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int unsigned OCC_MAX = 2;

  // Buffer occupancy for a state; an illegal encoding counts as full so it never pops
  function automatic logic [1:0] occupancy(input state_t s);
    case (s)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      default:  occupancy = 2'(OCC_MAX);
    endcase
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO pop side plus valid/ready output stream of the FIFO stream reader.
// master = reader, slave = the attached FIFO and stream sink.
interface fifo_stream_reader_if #(
  parameter int unsigned width = 8
);
  logic             fifo_empty;
  logic [width-1:0] fifo_read_data;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_pop, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_pop, out_valid, out_data
  );
endinterface

// File: rtl/ff_fifo_with_reg_empty_full.sv
// Push/pop FIFO with registered empty/full flags and a combinational head word.
module ff_fifo_with_reg_empty_full #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] read_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned ptr_width = $clog2(depth);
  localparam int unsigned cnt_width = $clog2(depth + 1);

  logic [width-1:0]     mem [depth];
  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic [cnt_width-1:0] cnt;
  logic [cnt_width-1:0] cnt_d;
  logic                 push_ok;
  logic                 pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign read_data = mem[rd_ptr];

  // Next fill level
  always_comb begin
    cnt_d = cnt;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt + cnt_width'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt - cnt_width'(1);
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, fill level and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == ptr_width'(depth - 1)) ? '0 : wr_ptr + ptr_width'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == ptr_width'(depth - 1)) ? '0 : rd_ptr + ptr_width'(1);
      end
      cnt   <= cnt_d;
      empty <= (cnt_d == '0);
      full  <= (cnt_d == cnt_width'(depth));
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO stream reader: drains a push/pop FIFO into a valid/ready stream through a
// 2-entry buffer so fifo_pop never depends on out_ready.
// Optional transfer counter enabled by FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned width = 8
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  parameter int unsigned count_width = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fifo_stream_reader_if.master   bus
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [count_width-1:0] word_count
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [width-1:0] head_q;
  logic [width-1:0] head_d;
  logic [width-1:0] tail_q;
  logic [width-1:0] tail_d;
  logic             pop;
  logic             take;

  assign pop           = !bus.fifo_empty && (occupancy(state_q) < 2'(OCC_MAX)) && !flush;
  assign take          = bus.out_valid && bus.out_ready;
  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = head_q;

  // Next buffer state; a popped word is captured on the same edge as the pop
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop) begin
            head_d  = bus.fifo_read_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && take) begin
            head_d = bus.fifo_read_data;
          end else if (pop) begin
            tail_d  = bus.fifo_read_data;
            state_d = ST_TWO;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Buffer state and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  // Completed-transfer counter; survives flush, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (take) begin
      word_count <= word_count + count_width'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader fed by ff_fifo_with_reg_empty_full.
// Words pushed into the FIFO are queued as expected output; a negedge monitor
// pops and compares on every stream transfer. Build with FIFO_STREAM_READER_STATS_EN
// to also cover the transfer counter (count_width=4 here).
module tb_fifo_stream_reader;
  localparam int unsigned width       = 8;
  localparam int unsigned count_width = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             push;
  logic [width-1:0] push_data;
  logic             full;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [count_width-1:0] word_count;
`endif

  fifo_stream_reader_if #(.width(width)) bus ();

  ff_fifo_with_reg_empty_full #(.width(width), .depth(10)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.fifo_pop),
    .read_data (bus.fifo_read_data),
    .empty     (bus.fifo_empty),
    .full      (full)
  );

`ifdef FIFO_STREAM_READER_STATS_EN
  fifo_stream_reader #(.width(width), .count_width(count_width)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus.master),
    .word_count (word_count)
  );
`else
  fifo_stream_reader #(.width(width)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.master)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [width-1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               exp_count = 0;
  int               pop_cnt = 0;
  logic             stall_seen = 1'b0;
  logic [width-1:0] stall_data = '0;
  logic             rand_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: stream transfers against the scoreboard, pop legality, stall stability
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (bus.fifo_pop) begin
        pop_cnt++;
        checks++;
        if (bus.fifo_empty) begin
          errors++;
          $display("FAIL pop_while_empty actual=1 required=0");
        end
      end
      if (stall_seen && bus.out_valid) begin
        checks++;
        if (bus.out_data !== stall_data) begin
          errors++;
          $display("FAIL stall_stable actual=%0h required=%0h", bus.out_data, stall_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", bus.out_data);
        end else begin
          logic [width-1:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            errors++;
            $display("FAIL stream_data actual=%0h required=%0h", bus.out_data, e);
          end
        end
      end
      stall_seen = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  // Push one word into the FIFO and record it as expected output
  task automatic push_word(input logic [width-1:0] d);
    push      = 1'b1;
    push_data = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    flush         = 1'b0;
    push          = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    exp_count = 0;
    pop_cnt   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait until every expected word has left the stream, bounded
  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    push          = 1'b0;
    push_data     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_pop", 32'(bus.fifo_pop), 32'd0);
    chk("reset_data", 32'(bus.out_data), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("reset_count", 32'(word_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming at full throughput
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 10; i++) push_word(8'(i));
      end
      begin
        int c = 0;
        int run = 1;
        @(negedge clk);
        while (bus.fifo_empty && c < 20) begin
          @(negedge clk);
          c++;
        end
        chk("latency_before", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("latency_first", 32'(bus.out_valid), 32'd1);
        repeat (9) begin
          @(negedge clk);
          if (bus.out_valid) run++;
        end
        chk("stream_run", 32'(run), 32'd10);
        @(negedge clk);
        chk("stream_end_valid", 32'(bus.out_valid), 32'd0);
      end
    join
    wait_drain("stream_drain", 50);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("stream_count", 32'(word_count), 32'd10);
`endif

    // Backpressure: buffer fills to two, third word stays in the FIFO
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_pops", 32'(pop_cnt), 32'd2);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_data", 32'(bus.out_data), 32'h11);
    chk("bp_pop_low", 32'(bus.fifo_pop), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_take_cycle", 32'(bus.fifo_pop), 32'd0);
    @(negedge clk);
    chk("bp_third_pop", 32'(bus.fifo_pop), 32'd1);
    wait_drain("bp_drain", 50);
    chk("bp_pops_total", 32'(pop_cnt), 32'd3);

    // Random data with random ready
    rand_done = 1'b0;
    fork
      begin
        int n = 0;
        while (n < 200) begin
          push = 1'b0;
          if ($urandom_range(0, 1) == 1 && !full) begin
            push      = 1'b1;
            push_data = width'($urandom);
            exp_q.push_back(push_data);
            n++;
          end
          @(posedge clk);
          #1;
        end
        push      = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("random_drain", 200);

    // Flush with two buffered and two in the FIFO; the flush-cycle take still counts
    do_reset();
    push_word(8'hA1);
    push_word(8'hB2);
    push_word(8'hC3);
    push_word(8'hD4);
    repeat (6) @(posedge clk);
    #1;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_pop", 32'(bus.fifo_pop), 32'd0);
    chk("flush_valid_in", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("flush_valid_after", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("flush_drain", 50);
    chk("flush_takes", 32'(exp_count), 32'd3);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("flush_count", 32'(word_count), 32'd3);
`endif

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    push_word(8'h5A);
    push_word(8'h6B);
    push_word(8'h7C);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_pop", 32'(bus.fifo_pop), 32'd0);
    chk("midrst_data", 32'(bus.out_data), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("midrst_count", 32'(word_count), 32'd0);
`endif
    exp_q.delete();
    exp_count = 0;
    pop_cnt   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_after_valid", 32'(bus.out_valid), 32'd0);

    // Seventeen transfers: a 4-bit counter wraps to 1
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(8'h40 + i));
    wait_drain("wrap_drain", 60);
    chk("wrap_takes", 32'(exp_count), 32'd17);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("wrap_count", 32'(word_count), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
